phi_receiver: RTL
=================

# phi_receiver

Receiving end of the phi setpoint path: takes the 32-bit phi word (degrees) produced by the button/7-segment phi selector and turns it into a safe, applied phase angle for the hybrid controller. The word arrives from a button-driven, clock-unrelated domain, so it is synchronised and stability-qualified. It is clamped to the legal range and slew-limited toward the new value. Each applied change is published in degrees and in centiradians, with a one-cycle update strobe.

## Interface
- STABLE_CYCLES, 1000: consecutive identical synchronised samples required to accept a new target
- TICK_DIV, 50000: clock cycles between slew steps
- STEP_DEG, 1: maximum change of applied angle per slew step (1..90)
- i_clock  input  1  system clock; single clock domain
- i_reset  input  1  reset; synchronous, active-high
- i_phi32  input  32  requested angle in degrees; asynchronous to i_clock; only [8:0] meaningful
- i_enable  input  1  1 = slewing allowed; 0 = freeze applied angle
- o_phi_deg  output  9  applied angle, degrees, 0..90
- o_phi_rad  output  32  applied angle in centiradians: (o_phi_deg*1787)>>10
- o_target  output  9  accepted, clamped target angle
- o_update  output  1  one-cycle pulse on every change of o_phi_deg
- o_busy  output  1  high while o_phi_deg != o_target

## Operation
- Input stage: two-flop synchroniser on i_phi32[8:0]; i_phi32[31:9] nonzero is treated as 9'd511.
- Clamp: synchronised value > 90 maps to 90. Values 0..90 pass unchanged.
- Qualifier: the stability counter resets whenever the clamped sample differs from the previous sample. When STABLE_CYCLES consecutive equal samples are seen and the value differs from o_target, o_target loads that value on the next edge. The qualifier runs in every FSM state.
- FSM states:
  - IDLE: o_phi_deg == o_target. On a target accept, go to SLEW.
  - SLEW: each time the tick counter reaches TICK_DIV-1 with i_enable=1, o_phi_deg moves toward o_target by min(STEP_DEG, |diff|), o_update pulses, and the tick counter clears. When o_phi_deg == o_target after the step, go to IDLE.
  - HOLD: entered from SLEW when i_enable=0. The tick counter and o_phi_deg are frozen. When i_enable returns to 1, go back to SLEW and resume counting from the frozen value.
- Target accept during SLEW or HOLD: o_target updates and the direction is recomputed. The tick counter is not cleared.
- Target equal to the current o_phi_deg (including a return during slew): the next evaluation finds diff=0, so no step and no o_update; go to IDLE.
- Arithmetic: o_phi_rad uses an 18-bit product (9b × 11b), zero-extended to 32 bits. The step comparison is signed 10-bit.

## Timing
- Reset: o_phi_deg=0, o_phi_rad=0, o_target=0, o_update=0, o_busy=0, state IDLE, synchroniser, stability and tick counters all 0. Asserted mid-slew, these values are reached on the next edge.
- Input change to o_target: 2 (sync) + STABLE_CYCLES cycles.
- Target accept to first step: TICK_DIV cycles, because the tick counter is cleared on IDLE→SLEW.
- o_phi_deg, o_phi_rad and o_update change on the same edge; o_update is registered.
- o_busy is registered and is valid the cycle after o_target or o_phi_deg changes.

## Structure
- Package phi_pkg: PHI_MAX_DEG=90, DEG2RAD_MUL=1787, DEG2RAD_SHIFT=10, FSM state enum (IDLE, SLEW, HOLD).
- Sub-module phi_qualifier: synchroniser, clamp and stability counter. Output is an accept pulse plus the value. It is instantiated once.
- The top level holds the FSM, tick divider, stepper and rad conversion.

## Test plan
All scenarios use STABLE_CYCLES=4, TICK_DIV=3, STEP_DEG=5.
- Reset, then hold i_phi32=40 → o_target=40 at cycle 6. Then 8 o_update pulses, 3 cycles apart, with o_phi_deg 5,10,…,40. Final o_phi_rad=69, and o_busy falls after the last step.
- i_phi32=200, then i_phi32=32'h0001_0000 → o_target=90 (o_phi_rad 157 when reached). The second value also clamps to 90, so no new accept.
- From settled 40, i_phi32=38 → a single step to 38, with exactly one o_update.
- Glitch: from settled 40, i_phi32=60 for 3 cycles, then back to 40 → o_target stays 40, no o_update.
- Mid-slew (0→40), drop i_enable for 10 cycles → o_phi_deg frozen with no pulses. It resumes on re-enable and reaches 40.
- Mid-slew, assert i_reset for 1 cycle → all outputs 0 on the next edge. With i_phi32 still 40, slewing restarts after 6 cycles.

Source files
------------

// File: rtl/phi_pkg.sv
// Shared constants, FSM encoding and the qualifier handoff type for the phi setpoint receiver.
package phi_pkg;

    localparam logic [8:0]  PHI_MAX_DEG   = 9'd90;
    localparam logic [10:0] DEG2RAD_MUL   = 11'd1787;
    localparam int          DEG2RAD_SHIFT = 10;

    typedef enum logic [1:0] {
        IDLE,
        SLEW,
        HOLD
    } phi_state_e;

    typedef struct packed {
        logic       accept;
        logic [8:0] value;
    } phi_qual_t;

    // 1787/1024 approximates 100*pi/180; the angle is capped at 90, so 18 bits holds the product
    function automatic logic [31:0] deg2rad(input logic [8:0] deg);
        logic [17:0] prod;
        prod = 18'(deg) * 18'(DEG2RAD_MUL);
        return 32'(prod >> DEG2RAD_SHIFT);
    endfunction

endpackage

// File: rtl/phi_qualifier.sv
// Brings the button-domain phi word into i_clock, clamps it, and flags a new target once the
// clamped value has held steady for STABLE_CYCLES samples (STABLE_CYCLES must be >= 2).
module phi_qualifier
    import phi_pkg::*;
#(
    parameter int STABLE_CYCLES = 1000
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic [31:0] i_phi32,
    input  logic [8:0]  i_target,
    output phi_qual_t   o_qual
);

    localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((STABLE_CYCLES > 2) ? STABLE_CYCLES - 2 : 0);

    // bit 9 carries "upper word nonzero" so out-of-range words clamp like 511 would
    logic [9:0]    sync1;
    logic [9:0]    sync2;
    logic [8:0]    sample;
    logic [8:0]    prev;
    logic [CW-1:0] cnt;
    logic          stable;

    always_comb begin
        sample = sync2[8:0];
        if (sync2[9] || sync2[8:0] > PHI_MAX_DEG)
            sample = PHI_MAX_DEG;
        stable = (sample == prev) && (cnt == CNT_LAST);
        o_qual.value  = sample;
        o_qual.accept = stable && (sample != i_target);
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
            cnt   <= '0;
        end else begin
            sync1 <= {|i_phi32[31:9], i_phi32[8:0]};
            sync2 <= sync1;
            prev  <= sample;
            if (sample != prev)
                cnt <= '0;
            else if (cnt != CNT_LAST)
                cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/phi_receiver.sv
// Turns the qualified phi target into a slew-limited applied angle, published in degrees and
// centiradians with a one-cycle update strobe.
module phi_receiver
    import phi_pkg::*;
#(
    parameter int STABLE_CYCLES = 1000,
    parameter int TICK_DIV      = 50000,
    parameter int STEP_DEG      = 1
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic [31:0] i_phi32,
    input  logic        i_enable,
    output logic [8:0]  o_phi_deg,
    output logic [31:0] o_phi_rad,
    output logic [8:0]  o_target,
    output logic        o_update,
    output logic        o_busy
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [8:0]    STEP_MAX  = 9'(STEP_DEG);

    phi_qual_t         qual;
    phi_state_e        state;
    logic [TW-1:0]     tick;
    logic [8:0]        tgt_nxt;
    logic signed [9:0] diff;
    logic [8:0]        mag;
    logic [8:0]        step;
    logic [8:0]        phi_step;

    phi_qualifier #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_qual (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_phi32 (i_phi32),
        .i_target(o_target),
        .o_qual  (qual)
    );

    // a target accepted on the same edge as a step steers that step
    always_comb begin
        tgt_nxt  = qual.accept ? qual.value : o_target;
        diff     = signed'({1'b0, tgt_nxt}) - signed'({1'b0, o_phi_deg});
        mag      = diff[9] ? 9'(-diff) : diff[8:0];
        step     = (mag > STEP_MAX) ? STEP_MAX : mag;
        phi_step = diff[9] ? (o_phi_deg - step) : (o_phi_deg + step);
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state     <= IDLE;
            tick      <= '0;
            o_phi_deg <= '0;
            o_phi_rad <= '0;
            o_target  <= '0;
            o_update  <= 1'b0;
            o_busy    <= 1'b0;
        end else begin
            o_update <= 1'b0;
            o_busy   <= (o_target != o_phi_deg);
            if (qual.accept)
                o_target <= qual.value;

            case (state)
                IDLE: begin
                    if (qual.accept) begin
                        state <= SLEW;
                        tick  <= '0;
                    end
                end
                SLEW: begin
                    if (!i_enable) begin
                        state <= HOLD;
                    end else if (tick == TICK_LAST) begin
                        tick <= '0;
                        if (mag == '0) begin
                            state <= IDLE;
                        end else begin
                            o_phi_deg <= phi_step;
                            o_phi_rad <= deg2rad(phi_step);
                            o_update  <= 1'b1;
                            if (phi_step == tgt_nxt)
                                state <= IDLE;
                        end
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                HOLD: begin
                    if (i_enable)
                        state <= SLEW;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
